// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage IF/ID/EX/MEM/WR core: writer scoreboard, IF/ID hold,
// ID/EX bubble, taken-branch flush and stall counter. Define FORWARD_EN for load-use-only interlock plus EX forwarding selects.
module pipe_hazard_ctrl #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_regwr,
   input  logic [RA_W-1:0]  id_rw,
   input  logic             id_load,
   input  logic             id_branch,
   input  logic             ex_taken,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } state_e;

   typedef struct packed {
      logic            v;
      logic            wr;
      logic [RA_W-1:0] rw;
      logic            ld;
      logic            br;
   } slot_t;

   localparam logic [1:0] FWD_RF = 2'b00;

   slot_t            ex_q, mem_q, wr_q, ex_d;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             ex_hit, mem_hit, br_taken, kill, hazard, issue;

   function automatic logic hit(slot_t s, logic use_r, logic [RA_W-1:0] r);
      return use_r & s.v & s.wr & (s.rw == r) & (r != '0);
   endfunction

   assign ex_hit  = hit(ex_q, id_use_rs, id_rs) | hit(ex_q, id_use_rt, id_rt);
   assign mem_hit = hit(mem_q, id_use_rs, id_rs) | hit(mem_q, id_use_rt, id_rt);

   // The register file writes before it reads, so the WR slot never takes part in hazard detection.
`ifdef FORWARD_EN
   assign hazard = id_valid & ex_q.ld & ex_hit;
`else
   assign hazard = id_valid & (ex_hit | mem_hit);
`endif

   assign br_taken = ex_q.br & ex_taken;
   assign kill     = br_taken | (state_q == ST_FLUSH);
   assign issue    = id_valid & ~hazard & ~kill;

   always_comb begin
      // NOTE: every output gets a default first so no path through the ifs can infer a latch.
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      state_d     = ST_RUN;
      if (!rst) begin
         if (kill) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = br_taken ? ST_FLUSH : ST_RUN;
         end else if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_STALL;
         end
      end
   end

   always_comb begin
      ex_d = '0;
      if (issue) begin
         ex_d.v  = 1'b1;
         ex_d.wr = id_regwr;
         ex_d.rw = id_rw;
         ex_d.ld = id_load;
         ex_d.br = id_branch;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_en && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wr_q        <= '0;
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
      end else begin
         wr_q        <= mem_q;
         mem_q       <= ex_q;
         ex_q        <= ex_d;
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef FORWARD_EN
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WR  = 2'b10;

   logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

   // The youngest writer (EX) wins when both EX and MEM hold the same destination.
   function automatic logic [1:0] fwd_sel(logic use_r, logic [RA_W-1:0] r, slot_t ex_s, slot_t mem_s);
      if (hit(ex_s, use_r, r))
         return FWD_MEM;
      if (hit(mem_s, use_r, r))
         return FWD_WR;
      return FWD_RF;
   endfunction

   always_comb begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
      if (issue) begin
         fwd_a_d = fwd_sel(id_use_rs, id_rs, ex_q, mem_q);
         fwd_b_d = fwd_sel(id_use_rt, id_rt, ex_q, mem_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else begin
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign fwd_a = fwd_a_q;
   assign fwd_b = fwd_b_q;
`else
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;
`endif

   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;

   // WR slot and the MEM-stage ld/br bits are carried only to keep the scoreboard complete.
   logic sb_unused;
   assign sb_unused = ^{wr_q, mem_q.ld, mem_q.br, ex_q.ld};

endmodule
